imm_extend_pipe: RTL and testbench

//  Parametrised, pipelined successor to the 16->32 sign extender in the decode path.

---
 rtl/ext_pkg.sv | 13 +
 rtl/ext_skid_buf.sv | 64 ++++++
 rtl/imm_extend_pipe.sv | 68 ++++++
 tb/tb_imm_extend_pipe.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ext_pkg.sv
// Shared mode encodings for the immediate extender.
package ext_pkg;

  localparam int EXT_MODE_W = 2;

  typedef logic [EXT_MODE_W-1:0] ext_mode_t;

  localparam ext_mode_t EXT_SIGN   = 2'b00;
  localparam ext_mode_t EXT_ZERO   = 2'b01;
  localparam ext_mode_t EXT_UPPER  = 2'b10;
  localparam ext_mode_t EXT_BRANCH = 2'b11;

endpackage

// File: rtl/ext_skid_buf.sv
// 2-entry FIFO with a registered head; empty-to-output latency 1 cycle.
// in_ready is a pure function of registered occupancy, so out_ready has no comb path to in_ready.
module ext_skid_buf #(
  parameter int W = 37
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [W-1:0] head;
  logic [W-1:0] tail;
  logic [1:0]   occ;
  logic         push;
  logic         pop;

  assign in_ready  = (occ != 2'd2);
  assign out_valid = (occ != 2'd0);
  assign out_data  = head;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // head always holds the oldest beat; tail only fills when head is stalled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head <= '0;
      tail <= '0;
      occ  <= 2'd0;
    end else begin
      case (occ)
        2'd0: begin
          if (push) begin
            head <= in_data;
            occ  <= 2'd1;
          end
        end
        2'd1: begin
          case ({push, pop})
            2'b11: head <= in_data;
            2'b10: begin
              tail <= in_data;
              occ  <= 2'd2;
            end
            2'b01: occ <= 2'd0;
            default: ;
          endcase
        end
        2'd2: begin
          if (pop) begin
            head <= tail;
            occ  <= 2'd1;
          end
        end
        default: occ <= 2'd0;
      endcase
    end
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Extends an immediate (sign/zero/upper/branch) and registers it with its tag; latency 1 cycle.
// 2-entry buffer absorbs consumer stalls; in_ready drops only when both entries are full.
module imm_extend_pipe
  import ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       in_imm,
  input  logic [EXT_MODE_W-1:0] in_mode,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W-1:0]      out_data,
  output logic [TAG_W-1:0]      out_tag,
  output logic                  out_neg
);

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic [TAG_W-1:0] tag;
  } beat_t;

  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] ext;
  beat_t            in_beat;
  beat_t            out_beat;

  assign sext = {{(OUT_W-IN_W){in_imm[IN_W-1]}}, in_imm};

  // branch offsets are word-aligned; bits shifted past the MSB are dropped
  always_comb begin
    ext = sext;
    case (in_mode)
      EXT_SIGN:   ext = sext;
      EXT_ZERO:   ext = {{(OUT_W-IN_W){1'b0}}, in_imm};
      EXT_UPPER:  ext = {in_imm, {(OUT_W-IN_W){1'b0}}};
      EXT_BRANCH: ext = sext << 2;
      default:    ext = sext;
    endcase
  end

  assign in_beat.data = ext;
  assign in_beat.tag  = in_tag;

  ext_skid_buf #(
    .W($bits(beat_t))
  ) u_buf (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_beat),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_beat)
  );

  assign out_data = out_beat.data;
  assign out_tag  = out_beat.tag;
  assign out_neg  = out_beat.data[OUT_W-1];

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed-vector bench for imm_extend_pipe with a queue scoreboard and independent output monitor.
module tb_imm_extend_pipe;
  import ext_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  logic [1:0]  in_mode;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_tag;
  logic        out_neg;

  imm_extend_pipe #(.IN_W(16), .OUT_W(32), .TAG_W(5)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_imm   (in_imm),
    .in_mode  (in_mode),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_tag  (out_tag),
    .out_neg  (out_neg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pops   = 0;
  bit rnd_en = 1'b0;
  logic [36:0] q[$];

  logic [15:0] v_imm [10];
  logic [1:0]  v_mode[10];
  logic [31:0] v_exp [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: every consumed beat must match the oldest expected entry
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got data %h tag %0d expected no beat", out_data, out_tag);
      end else begin
        logic [36:0] e;
        e = q.pop_front();
        chk("out_data", out_data, e[36:5]);
        chk("out_tag", {27'd0, out_tag}, {27'd0, e[4:0]});
        chk("out_neg", {31'd0, out_neg}, {31'd0, e[36]});
      end
      pops++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_en) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [15:0] imm, input logic [1:0] mode,
                      input logic [4:0] tag, input logic [31:0] exp);
    bit done = 1'b0;
    in_valid = 1'b1;
    in_imm   = imm;
    in_mode  = mode;
    in_tag   = tag;
    for (int n = 0; n < 64 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back({exp, tag});
        done = 1'b1;
      end
      tick();
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready 0 for 64 cycles expected acceptance");
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    v_imm[0] = 16'h8001; v_mode[0] = EXT_SIGN;   v_exp[0] = 32'hFFFF8001;
    v_imm[1] = 16'h8001; v_mode[1] = EXT_ZERO;   v_exp[1] = 32'h00008001;
    v_imm[2] = 16'h8001; v_mode[2] = EXT_UPPER;  v_exp[2] = 32'h80010000;
    v_imm[3] = 16'hFFFF; v_mode[3] = EXT_BRANCH; v_exp[3] = 32'hFFFFFFFC;
    v_imm[4] = 16'h7FFF; v_mode[4] = EXT_BRANCH; v_exp[4] = 32'h0001FFFC;
    v_imm[5] = 16'h7FFF; v_mode[5] = EXT_SIGN;   v_exp[5] = 32'h00007FFF;
    v_imm[6] = 16'h0000; v_mode[6] = EXT_UPPER;  v_exp[6] = 32'h00000000;
    v_imm[7] = 16'h1234; v_mode[7] = EXT_BRANCH; v_exp[7] = 32'h000048D0;
    v_imm[8] = 16'h8000; v_mode[8] = EXT_BRANCH; v_exp[8] = 32'hFFFE0000;
    v_imm[9] = 16'hFFFF; v_mode[9] = EXT_ZERO;   v_exp[9] = 32'h0000FFFF;

    reset_n = 1'b0; in_valid = 1'b0; in_imm = '0; in_mode = '0; in_tag = '0; out_ready = 1'b1;
    #23;
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_tag", {27'd0, out_tag}, 0);
    chk("rst_out_neg", {31'd0, out_neg}, 0);
    reset_n = 1'b1;
    tick();
    chk("rst_in_ready", {31'd0, in_ready}, 1);

    // T1-T3: each mode, one beat at a time, 1-cycle latency
    for (int i = 0; i < 10; i++) begin
      send(v_imm[i], v_mode[i], 5'(i), v_exp[i]);
      chk("latency_valid", {31'd0, out_valid}, 1);
      tick();
    end
    drain();

    // T4: fill both entries while stalled, third push must be ignored
    out_ready = 1'b0;
    send(v_imm[0], v_mode[0], 5'd1, v_exp[0]);
    send(v_imm[3], v_mode[3], 5'd2, v_exp[3]);
    chk("full_in_ready", {31'd0, in_ready}, 0);
    chk("full_out_valid", {31'd0, out_valid}, 1);
    in_valid = 1'b1; in_imm = 16'h5555; in_mode = EXT_ZERO; in_tag = 5'd3;
    tick(); tick();
    in_valid = 1'b0;
    chk("stall_in_ready", {31'd0, in_ready}, 0);
    chk("stall_out_tag", {27'd0, out_tag}, 1);
    chk("stall_out_data", out_data, v_exp[0]);
    out_ready = 1'b1;
    @(negedge clk);
    chk("pre_pop_in_ready", {31'd0, in_ready}, 0);
    tick();
    chk("post_pop_in_ready", {31'd0, in_ready}, 1);
    chk("post_pop_out_tag", {27'd0, out_tag}, 2);
    drain();
    tick();
    chk("ignored_beat_absent", {31'd0, out_valid}, 0);

    // T5: back-to-back stream, one beat per cycle, no bubbles
    begin
      int base;
      base = pops;
      for (int i = 0; i < 8; i++) begin
        send(v_imm[i], v_mode[i], 5'(8 + i), v_exp[i]);
        chk("stream_valid", {31'd0, out_valid}, 1);
        chk("stream_pops", pops - base, i);
      end
      drain();
    end

    // T5b: random consumer stalls, scoreboard catches loss or duplication
    rnd_en = 1'b1;
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < 10; i++)
        send(v_imm[i], v_mode[i], 5'(i + 10 * r), v_exp[i]);
    drain();
    rnd_en = 1'b0;
    out_ready = 1'b1;
    drain();

    // T6: asynchronous reset with two beats buffered
    out_ready = 1'b0;
    send(v_imm[2], v_mode[2], 5'd20, v_exp[2]);
    send(v_imm[8], v_mode[8], 5'd21, v_exp[8]);
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_out_tag", {27'd0, out_tag}, 0);
    chk("arst_out_neg", {31'd0, out_neg}, 0);
    q.delete();
    tick(); tick();
    reset_n = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("post_rst_in_ready", {31'd0, in_ready}, 1);
    for (int i = 0; i < 4; i++) tick();
    chk("post_rst_no_beat", {31'd0, out_valid}, 0);
    send(v_imm[4], v_mode[4], 5'd30, v_exp[4]);
    drain();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
